// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline sequencer state.
// Imported by pipeline_ctrl and hazard_detect.
package cpu_types_pkg;

  localparam int REGBITS = 5;

  typedef logic [REGBITS-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DDONE  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX-stage load and ID sources.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect
  import cpu_types_pkg::*;
#(
  parameter int REG_W = REGBITS
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             loaduse
);

  logic rt_nz;
  logic hit;

  assign rt_nz   = |ex_rt;
  assign hit     = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign loaduse = ex_memread & rt_nz & hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register / PC sequencer with dmem completion tracking.
// Optional perf counters (stall_cnt, flush_cnt) under PIPE_PERF_EN.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W = REGBITS,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_pcsrc,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             dmem_gate,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             halt
);

  pipe_state_t state_q, state_d;
  logic        halt_q, halt_d;
  logic        memop;
  logic        advance;
  logic        loaduse;
  logic        bubble;
  logic        squash;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .ex_memread(ex_memread),
    .ex_rt     (ex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .loaduse   (loaduse)
  );

  assign memop = mem_dren | mem_dwen;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    advance   = 1'b0;
    state_d   = state_q;
    dmem_gate = 1'b0;
    unique case (state_q)
      RUN: begin
        dmem_gate = 1'b1;
        advance   = ihit & (~memop | dhit);
        if (memop & ~dhit)
          state_d = DWAIT;
        else if (memop & dhit & ~ihit)
          state_d = DDONE;
        else if (advance & mem_halt)
          state_d = HALTED;
      end
      DWAIT: begin
        dmem_gate = 1'b1;
        advance   = ihit & dhit;
        if (dhit & ihit)
          state_d = mem_halt ? HALTED : RUN;
        else if (dhit)
          state_d = DDONE;
      end
      DDONE: begin
        advance = ihit;
        if (ihit)
          state_d = mem_halt ? HALTED : RUN;
      end
      HALTED: begin
        advance = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // A taken branch squashes the ID instruction, so its hazard is moot.
  assign squash = advance & ex_pcsrc;
  assign bubble = advance & ~ex_pcsrc & loaduse;
  assign halt_d = halt_q | (advance & mem_halt);

  always_comb begin
    pc_en      = advance & ~bubble;
    ifid_en    = advance & ~bubble;
    idex_en    = advance;
    exmem_en   = advance;
    memwb_en   = advance;
    ifid_flush = squash;
    idex_flush = squash | bubble;
  end

  assign halt = halt_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_ev;

  assign stall_ev = (state_q != HALTED) & (~advance | bubble);

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_ev && stall_q != '1)
      stall_d = stall_q + 1'b1;
    if (squash && flush_q != '1)
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule
